// File: rtl/vram_arbiter_pkg.sv
// Shared types and defaults for the video-RAM arbiter.
// The grant and the return tag use one encoding, so a grant can be registered
// directly as the tag for the following cycle.
package vram_arb_pkg;

  localparam int ADDR_W_DEF       = 16;
  localparam int DATA_W_DEF       = 8;
  localparam int FIFO_DEPTH_DEF   = 8;
  localparam int LOW_WATER_DEF    = 4;
  localparam int CPU_MAX_WAIT_DEF = 6;

  // Owner of the RAM port in a cycle, and owner of the data returning one cycle later.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2
  } gnt_e;

  // Width of a counter that must hold every value from 0 to depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of the CPU, video-stream and RAM-port signals around the arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding system (CPU, video controller and RAM together).
interface vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              vid_start;
  logic [ADDR_W-1:0] vid_base;
  logic [ADDR_W-1:0] vid_len;
  logic              vid_pop;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_data;
  logic              vid_underrun;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  vid_start, vid_base, vid_len, vid_pop,
    output vid_valid, vid_data, vid_underrun,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output vid_start, vid_base, vid_len, vid_pop,
    input  vid_valid, vid_data, vid_underrun,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/vram_prefetch_fifo.sv
// Small synchronous FIFO holding prefetched video bytes.
// The head is always visible, and it reads as zero while the FIFO is empty.
// Flush wins over a push or a pop in the same cycle. Callers pass pop
// unqualified: a pop while empty is ignored here.
module vram_prefetch_fifo
  import vram_arb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = DATA_W_DEF,
  localparam int LVL_W = level_w(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             pix_clk,
  input  logic             act_reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [LVL_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Next pointers and level. The depth is a power of two, so the pointers wrap naturally.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != LVL_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Pointer and level registers.
  always_ff @(posedge pix_clk) begin
    if (act_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write. The array has no reset because the level alone says what is valid.
  always_ff @(posedge pix_clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video-RAM arbiter. It issues at most one RAM operation per cycle,
// shared between a prefetching video read stream and single-byte CPU accesses.
// The grant is combinational from registered state. A one-cycle return tag
// routes the registered RAM read data to the FIFO or to the CPU.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int LOW_WATER    = LOW_WATER_DEF,
  parameter int CPU_MAX_WAIT = CPU_MAX_WAIT_DEF
) (
  input  logic           pix_clk,
  input  logic           act_reset,
  vram_arbiter_if.slave  bus
);

  localparam int LVL_W  = level_w(FIFO_DEPTH);
  localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);

  gnt_e              gnt;
  gnt_e              tag_q, tag_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              cpu_rd_q, cpu_rd_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  logic [LVL_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic [LVL_W:0]    committed;
  logic              vid_elig, cpu_elig, cpu_urgent, vid_low;
  logic              fifo_push, fifo_pop, fifo_flush;

  // Grant selection.
  // The FIFO must have room for every byte already requested, including the
  // one in flight. The wait-counter override keeps a busy video stream from
  // starving the CPU.
  always_comb begin
    committed  = {1'b0, fifo_count} + (LVL_W + 1)'(tag_q == GNT_VID);
    vid_elig   = !act_reset && !bus.vid_start && (remaining_q != '0) &&
                 (committed < (LVL_W + 1)'(FIFO_DEPTH));
    cpu_elig   = !act_reset && bus.cpu_req && (tag_q != GNT_CPU);
    cpu_urgent = (wait_q >= WAIT_W'(CPU_MAX_WAIT));
    vid_low    = (fifo_count < LVL_W'(LOW_WATER));
    gnt        = GNT_NONE;
    if (cpu_elig && cpu_urgent)      gnt = GNT_CPU;
    else if (vid_elig && vid_low)    gnt = GNT_VID;
    else if (cpu_elig)               gnt = GNT_CPU;
    else if (vid_elig)               gnt = GNT_VID;
  end

  // Drive the RAM port for the granted owner. The port is all zeros when idle.
  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    case (gnt)
      GNT_VID: bus.ram_addr = ptr_q;
      GNT_CPU: begin
        bus.ram_addr  = bus.cpu_addr;
        bus.ram_we    = bus.cpu_we;
        bus.ram_wdata = bus.cpu_we ? bus.cpu_wdata : '0;
      end
      default: ;
    endcase
  end

  // Next-state values for the stream pointer, the wait counter and the return path.
  always_comb begin
    tag_d       = gnt;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    wait_d      = wait_q;
    cpu_rd_d    = cpu_rd_q;
    cpu_rdata_d = cpu_rdata_q;

    if (bus.vid_start) begin
      ptr_d       = bus.vid_base;
      remaining_d = bus.vid_len;
    end else if (gnt == GNT_VID) begin
      ptr_d       = ptr_q + ADDR_W'(1);
      remaining_d = remaining_q - ADDR_W'(1);
    end

    // Counting stops at the threshold, and that value already forces the grant.
    if (!bus.cpu_req || (gnt == GNT_CPU)) wait_d = '0;
    else if (cpu_elig && !cpu_urgent)      wait_d = wait_q + WAIT_W'(1);

    if (gnt == GNT_CPU) cpu_rd_d = !bus.cpu_we;

    // Keep the last read value so that cpu_rdata holds steady across writes.
    if ((tag_q == GNT_CPU) && cpu_rd_q) cpu_rdata_d = bus.ram_rdata;
  end

  // Arbiter state registers.
  always_ff @(posedge pix_clk) begin
    if (act_reset) begin
      tag_q       <= GNT_NONE;
      ptr_q       <= '0;
      remaining_q <= '0;
      wait_q      <= '0;
      cpu_rd_q    <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      tag_q       <= tag_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      wait_q      <= wait_d;
      cpu_rd_q    <= cpu_rd_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  // A restart drops the returning video byte and any pop issued in that cycle.
  assign fifo_flush = bus.vid_start;
  assign fifo_push  = (tag_q == GNT_VID) && !bus.vid_start;
  assign fifo_pop   = bus.vid_pop && !bus.vid_start;

  vram_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .pix_clk   (pix_clk),
    .act_reset (act_reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .wdata     (bus.ram_rdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign bus.cpu_ack      = (tag_q == GNT_CPU);
  assign bus.cpu_rdata    = ((tag_q == GNT_CPU) && cpu_rd_q) ? bus.ram_rdata : cpu_rdata_q;
  assign bus.vid_valid    = (fifo_count != '0);
  assign bus.vid_data     = fifo_head;
  assign bus.vid_underrun = !act_reset && bus.vid_pop && !bus.vid_start && (fifo_count == '0);

endmodule
